// File: rtl/ex_muldiv.sv
// ex_muldiv: MIPS execute stage with HI/LO, single-cycle multiplier and an
// optional iterative radix-2 restoring divider built when EX_MULDIV_DIV_EN is defined.
module ex_muldiv #(
  parameter int DATA_W    = 32,
  parameter int REGADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           aluop_i,
  input  logic [2:0]           alusel_i,
  input  logic [DATA_W-1:0]    reg1_i,
  input  logic [DATA_W-1:0]    reg2_i,
  input  logic [REGADDR_W-1:0] wd_i,
  input  logic                 wreg_i,
  input  logic                 flush_i,
  output logic [REGADDR_W-1:0] wd_o,
  output logic                 wreg_o,
  output logic [DATA_W-1:0]    wdata_o,
  output logic [DATA_W-1:0]    hi_o,
  output logic [DATA_W-1:0]    lo_o,
  output logic                 stallreq_o
);
  localparam logic [7:0] OP_OR = 8'h25, OP_AND = 8'h24, OP_XOR = 8'h26, OP_NOR = 8'h27;
  localparam logic [7:0] OP_SLL = 8'h7C, OP_SRL = 8'h02, OP_SRA = 8'h03;
  localparam logic [7:0] OP_ADDU = 8'h21, OP_SUBU = 8'h23, OP_SLT = 8'h2A, OP_SLTU = 8'h2B;
  localparam logic [7:0] OP_MFHI = 8'h10, OP_MTHI = 8'h11, OP_MFLO = 8'h12, OP_MTLO = 8'h13;
  localparam logic [7:0] OP_MULT = 8'h18, OP_MULTU = 8'h19, OP_DIV = 8'h1A, OP_DIVU = 8'h1B;

  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [DATA_W-1:0]   logic_r, shift_r, arith_r, move_r, res, sra_r;
  logic [2*DATA_W-1:0] sprod, uprod, prod;
  logic [4:0]          shamt;
  logic                slt, sltu, is_mul, div_wr, stall;
  logic [DATA_W-1:0]   div_hi, div_lo;

  assign shamt = reg1_i[4:0];
  assign sra_r = $signed(reg2_i) >>> shamt;
  assign slt   = $signed(reg1_i) < $signed(reg2_i);
  assign sltu  = reg1_i < reg2_i;
  assign sprod = $signed({{DATA_W{reg1_i[DATA_W-1]}}, reg1_i}) * $signed({{DATA_W{reg2_i[DATA_W-1]}}, reg2_i});
  assign uprod = {{DATA_W{1'b0}}, reg1_i} * {{DATA_W{1'b0}}, reg2_i};
  assign prod   = aluop_i == OP_MULT ? sprod : uprod;
  assign is_mul = aluop_i == OP_MULT || aluop_i == OP_MULTU;

  always_comb begin
    logic_r = aluop_i == OP_OR  ? reg1_i | reg2_i :
              aluop_i == OP_AND ? reg1_i & reg2_i :
              aluop_i == OP_XOR ? reg1_i ^ reg2_i :
              aluop_i == OP_NOR ? ~(reg1_i | reg2_i) : '0;
    shift_r = aluop_i == OP_SLL ? reg2_i << shamt :
              aluop_i == OP_SRL ? reg2_i >> shamt :
              aluop_i == OP_SRA ? sra_r : '0;
    arith_r = aluop_i == OP_ADDU ? reg1_i + reg2_i :
              aluop_i == OP_SUBU ? reg1_i - reg2_i :
              aluop_i == OP_SLT  ? {{(DATA_W-1){1'b0}}, slt} :
              aluop_i == OP_SLTU ? {{(DATA_W-1){1'b0}}, sltu} : '0;
    move_r  = aluop_i == OP_MFHI ? hi_q : aluop_i == OP_MFLO ? lo_q : '0;
    res     = alusel_i == 3'd1 ? logic_r :
              alusel_i == 3'd2 ? shift_r :
              alusel_i == 3'd3 ? arith_r :
              alusel_i == 3'd4 ? move_r : '0;
    hi_d    = div_wr ? div_hi : aluop_i == OP_MTHI ? reg1_i : is_mul ? prod[2*DATA_W-1:DATA_W] : hi_q;
    lo_d    = div_wr ? div_lo : aluop_i == OP_MTLO ? reg1_i : is_mul ? prod[DATA_W-1:0] : lo_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign wdata_o    = rst ? '0 : res;
  assign wd_o       = rst ? '0 : wd_i;
  assign wreg_o     = rst ? 1'b0 : wreg_i;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign stallreq_o = stall & ~rst;

`ifdef EX_MULDIV_DIV_EN
  localparam int CW = $clog2(DATA_W) + 1;
  typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_ON, S_END} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, abs1, abs2;
  logic [DATA_W:0]   sh, diff;
  logic              is_div, sgn, ge;

  assign is_div = aluop_i == OP_DIV || aluop_i == OP_DIVU;
  assign sgn    = aluop_i == OP_DIV;
  assign abs1   = sgn && reg1_i[DATA_W-1] ? -reg1_i : reg1_i;
  assign abs2   = sgn && reg2_i[DATA_W-1] ? -reg2_i : reg2_i;
  // Partial remainder stays below the divisor, so bit DATA_W of diff is a clean borrow flag.
  assign sh     = {rem_q, quo_q[DATA_W-1]};
  assign diff   = sh - {1'b0, dvs_q};
  assign ge     = ~diff[DATA_W];
  assign div_lo = sgn && (reg1_i[DATA_W-1] ^ reg2_i[DATA_W-1]) ? -quo_q : quo_q;
  assign div_hi = sgn && reg1_i[DATA_W-1] ? -rem_q : rem_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    stall   = 1'b0;
    div_wr  = 1'b0;
    if (flush_i) state_d = S_IDLE;
    else case (state_q)
      S_IDLE: if (is_div) begin
        stall   = 1'b1;
        rem_d   = '0;
        quo_d   = reg2_i == '0 ? '0 : abs1;
        dvs_d   = abs2;
        cnt_d   = '0;
        state_d = reg2_i == '0 ? S_DIVZERO : S_ON;
      end
      S_DIVZERO: begin
        stall   = 1'b1;
        state_d = S_END;
      end
      S_ON: begin
        stall   = 1'b1;
        rem_d   = ge ? diff[DATA_W-1:0] : sh[DATA_W-1:0];
        quo_d   = {quo_q[DATA_W-2:0], ge};
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == CW'(DATA_W - 1) ? S_END : S_ON;
      end
      S_END: begin
        div_wr  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
    end
  end
`else
  logic unused_flush;
  assign unused_flush = flush_i;
  assign stall        = 1'b0;
  assign div_wr       = 1'b0;
  assign div_hi       = '0;
  assign div_lo       = '0;
`endif
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed plus randomized checks of ex_muldiv against a plain-arithmetic
// reference model; divider expectations follow whether EX_MULDIV_DIV_EN is defined.
module tb_ex_muldiv;
  localparam logic [7:0] OR_ = 8'h25, AND_ = 8'h24, XOR_ = 8'h26, NOR_ = 8'h27;
  localparam logic [7:0] SLL = 8'h7C, SRL = 8'h02, SRA = 8'h03;
  localparam logic [7:0] ADDU = 8'h21, SUBU = 8'h23, SLT = 8'h2A, SLTU = 8'h2B;
  localparam logic [7:0] MFHI = 8'h10, MTHI = 8'h11, MFLO = 8'h12, MTLO = 8'h13;
  localparam logic [7:0] MULT = 8'h18, MULTU = 8'h19, DIV = 8'h1A, DIVU = 8'h1B, NOP = 8'h00;
`ifdef EX_MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b1;
  logic [7:0]  aluop = NOP;
  logic [2:0]  alusel = 3'd0;
  logic [31:0] r1 = '0, r2 = '0;
  logic [4:0]  wd = '0;
  logic        wreg = 1'b0, flush = 1'b0;
  logic [4:0]  wd_o;
  logic        wreg_o, stallreq_o;
  logic [31:0] wdata_o, hi_o, lo_o;
  int          checks = 0, failures = 0;
  logic [31:0] mhi = '0, mlo = '0;

  ex_muldiv dut (
    .clk(clk), .rst(rst), .aluop_i(aluop), .alusel_i(alusel), .reg1_i(r1), .reg2_i(r2),
    .wd_i(wd), .wreg_i(wreg), .flush_i(flush), .wd_o(wd_o), .wreg_o(wreg_o),
    .wdata_o(wdata_o), .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_res(input logic [7:0] op, input logic [2:0] sel,
                                            input logic [31:0] a, input logic [31:0] b);
    int unsigned s = a[4:0];
    longint sb = longint'($signed(b));
    case (sel)
      3'd1: return op == OR_ ? (a | b) : op == AND_ ? (a & b) : op == XOR_ ? (a ^ b) :
                   op == NOR_ ? ~(a | b) : 32'd0;
      3'd2: return op == SLL ? (b << s) : op == SRL ? (b >> s) :
                   op == SRA ? 32'(sb / (longint'(1) << s) - ((sb < 0 && (sb % (longint'(1) << s)) != 0) ? 1 : 0)) : 32'd0;
      3'd3: return op == ADDU ? a + b : op == SUBU ? a - b :
                   op == SLT ? {31'd0, $signed(a) < $signed(b)} : op == SLTU ? {31'd0, a < b} : 32'd0;
      3'd4: return op == MFHI ? mhi : op == MFLO ? mlo : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
    aluop = op; alusel = sel; r1 = a; r2 = b;
  endtask

  // One non-divide op: combinational result now, HI/LO effect after the edge.
  task automatic step(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
    longint p;
    drive(op, sel, a, b);
    wd = 5'($urandom); wreg = 1'($urandom);
    @(negedge clk);
    chk("wdata", wdata_o, model_res(op, sel, a, b));
    chk("wd", 32'(wd_o), 32'(wd));
    chk("wreg", 32'(wreg_o), 32'(wreg));
    chk("hi", hi_o, mhi);
    chk("lo", lo_o, mlo);
    chk("nostall", 32'(stallreq_o), 32'd0);
    if (op == MTHI) mhi = a;
    if (op == MTLO) mlo = a;
    if (op == MULT) begin p = longint'($signed(a)) * longint'($signed(b)); {mhi, mlo} = 64'(p); end
    if (op == MULTU) {mhi, mlo} = {32'd0, a} * {32'd0, b};
    @(posedge clk); #1;
  endtask

  task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [31:0] q, r;
    int n = 0, exp_n;
    sa = op == DIV ? longint'($signed(a)) : longint'(a);
    sb = op == DIV ? longint'($signed(b)) : longint'(b);
    q = b == 0 ? 32'd0 : 32'(sa / sb);
    r = b == 0 ? 32'd0 : 32'(sa % sb);
    exp_n = !DIV_EN ? 0 : b == 0 ? 2 : 33;
    drive(op, 3'd0, a, b); wd = '0; wreg = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stallreq_o) break;
      n++;
      @(posedge clk); #1;
    end
    chk("div_stall_cycles", n, exp_n);
    chk("div_end_wdata", wdata_o, 32'd0);
    chk("div_end_hi_old", hi_o, mhi);
    chk("div_end_lo_old", lo_o, mlo);
    @(posedge clk); #1;
    drive(NOP, 3'd0, '0, '0);
    if (DIV_EN) begin mhi = r; mlo = q; end
    @(negedge clk);
    chk("div_hi", hi_o, mhi);
    chk("div_lo", lo_o, mlo);
    chk("div_after_stall", 32'(stallreq_o), 32'd0);
    @(posedge clk); #1;
  endtask

  logic [7:0] rops [18] = '{OR_, AND_, XOR_, NOR_, SLL, SRL, SRA, ADDU, SUBU, SLT, SLTU,
                            MFHI, MTHI, MFLO, MTLO, MULT, MULTU, 8'h3F};
  logic [2:0] rsel [18] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3,
                            3'd4, 3'd4, 3'd4, 3'd4, 3'd0, 3'd0, 3'd3};

  initial begin
    drive(OR_, 3'd1, 32'hFFFF_FFFF, 32'h1234_5678); wd = 5'd5; wreg = 1'b1;
    @(posedge clk); #1;
    chk("rst_wdata", wdata_o, 32'd0);
    chk("rst_wd", 32'(wd_o), 32'd0);
    chk("rst_wreg", 32'(wreg_o), 32'd0);
    chk("rst_hi", hi_o, 32'd0);
    chk("rst_lo", lo_o, 32'd0);
    chk("rst_stall", 32'(stallreq_o), 32'd0);
    rst = 1'b0;
    drive(OR_, 3'd1, 32'h0000_F0F0, 32'h0F0F_0000);
    @(negedge clk); chk("or_const", wdata_o, 32'h0F0F_F0F0);
    @(posedge clk); #1; drive(SRA, 3'd2, 32'd4, 32'h8000_0000);
    @(negedge clk); chk("sra_const", wdata_o, 32'hF800_0000);
    @(posedge clk); #1; drive(SLT, 3'd3, 32'hFFFF_FFFF, 32'd1);
    @(negedge clk); chk("slt_const", wdata_o, 32'd1);
    @(posedge clk); #1;
    step(MULT, 3'd0, 32'hFFFF_FFFF, 32'd2);
    chk("mult_hi_const", hi_o, 32'hFFFF_FFFF);
    chk("mult_lo_const", lo_o, 32'hFFFF_FFFE);
    step(MFHI, 3'd4, '0, '0);
    step(MFLO, 3'd4, '0, '0);
    step(MULTU, 3'd0, 32'hFFFF_FFFF, 32'd2);
    chk("multu_hi_const", hi_o, 32'd1);
    chk("multu_lo_const", lo_o, 32'hFFFF_FFFE);
    step(MFHI, 3'd4, '0, '0);
    step(MFLO, 3'd4, '0, '0);
    run_div(DIVU, 32'd100, 32'd7);
    run_div(DIV, 32'hFFFF_FFF9, 32'd2);
    run_div(DIV, 32'd1234, 32'd0);
    // Flush a divide in its eleventh cycle; preloaded HI/LO must survive.
    step(MTHI, 3'd4, 32'h1234_5678, '0);
    step(MTLO, 3'd4, 32'h1234_5678, '0);
    drive(DIVU, 3'd0, 32'd100, 32'd7);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); chk("flush_pre_stall", 32'(stallreq_o), 32'(DIV_EN));
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    chk("flush_stall", 32'(stallreq_o), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; drive(NOP, 3'd0, '0, '0);
    @(negedge clk);
    chk("flush_hi", hi_o, 32'h1234_5678);
    chk("flush_lo", lo_o, 32'h1234_5678);
    chk("flush_idle", 32'(stallreq_o), 32'd0);
    @(posedge clk); #1;
    run_div(DIVU, 32'd100, 32'd7);
    // Asynchronous reset in divide cycle 5.
    step(MTHI, 3'd4, 32'hDEAD_BEEF, '0);
    step(MTLO, 3'd4, 32'hCAFE_F00D, '0);
    drive(DIV, 3'd0, 32'hFFFF_FFF9, 32'd2);
    repeat (5) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    chk("arst_stall", 32'(stallreq_o), 32'd0);
    chk("arst_hi", hi_o, 32'd0);
    chk("arst_lo", lo_o, 32'd0);
    chk("arst_wdata", wdata_o, 32'd0);
    mhi = '0; mlo = '0;
    @(posedge clk); #1;
    drive(NOP, 3'd0, '0, '0); rst = 1'b0;
    step(NOP, 3'd0, '0, '0);
    run_div(DIV, 32'hFFFF_FFF9, 32'd2);
    for (int i = 0; i < 60; i++) begin
      int k = $urandom_range(0, 17);
      step(rops[k], $urandom_range(0, 7) == 0 ? 3'($urandom) : rsel[k], $urandom, $urandom);
    end
    for (int i = 0; i < 6; i++) begin
      logic [31:0] b = $urandom_range(0, 3) == 0 ? 32'($urandom_range(1, 20)) : $urandom;
      run_div($urandom_range(0, 1) == 0 ? DIV : DIVU, $urandom, b);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Parametrised MIPS execute stage, the successor to the single-operation OR-only execute stage. Sits between the id_ex and ex_mem stage registers. Provides:
- logic, shift and arithmetic results in one cycle;
- architectural HI/LO registers;
- a single-cycle multiplier;
- an iterative radix-2 divider that stalls the pipeline through `stallreq_o` until the quotient and remainder are ready.

## Interface
Parameters:
- DATA_W, 32, operand/result width; divider iterates DATA_W cycles
- REGADDR_W, 5, destination register address width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- aluop_i  in  8  operation code
- alusel_i  in  3  result class: 0 NOP, 1 LOGIC, 2 SHIFT, 3 ARITH, 4 MOVE
- reg1_i  in  DATA_W  operand 1; shift amount in reg1_i[4:0]
- reg2_i  in  DATA_W  operand 2; shifted value
- wd_i  in  REGADDR_W  destination register
- wreg_i  in  1  destination write enable
- flush_i  in  1  abort the in-flight divide
- wd_o  out  REGADDR_W  equals wd_i
- wreg_o  out  1  equals wreg_i
- wdata_o  out  DATA_W  result selected by alusel_i
- hi_o  out  DATA_W  HI register
- lo_o  out  DATA_W  LO register
- stallreq_o  out  1  hold the upstream pipeline; inputs must stay stable while high

## Operation
aluop codes:
- OR 0x25, AND 0x24, XOR 0x26, NOR 0x27
- SLL 0x7C, SRL 0x02, SRA 0x03
- ADDU 0x21, SUBU 0x23, SLT 0x2A (signed), SLTU 0x2B
- MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13
- MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B
- Any other code gives result 0.

Combinational result path:
- wdata_o = class result selected by alusel_i; 0 for NOP or an unknown class.
- MOVE class returns the current hi_o (MFHI) or lo_o (MFLO).
- ADDU/SUBU wrap modulo 2^DATA_W. No overflow trap.
- SRA replicates reg2_i[DATA_W-1].

HI/LO updates, all at the rising clock edge while the op is presented:
- MTHI/MTLO write reg1_i.
- MULT/MULTU: 2·DATA_W-bit product, signed or unsigned; HI = upper half, LO = lower half. Written the same cycle, no stall.
- A following MFHI/MFLO reads the new value.

Divider FSM, states IDLE, DIVZERO, ON, END:
- IDLE, DIV/DIVU presented, no flush:
  - reg2_i==0: go to DIVZERO.
  - otherwise: latch absolute values (DIV) or raw operands (DIVU), clear the counter, go to ON.
  - stallreq_o=1 in both cases.
- ON: one restoring subtract-shift step per cycle, stallreq_o=1. After DATA_W steps, go to END.
- DIVZERO: stallreq_o=1, go to END with quotient=0 and remainder=0.
- END: stallreq_o=0.
  - DIV sign fix: quotient is negated when the operand signs differ; remainder takes the dividend's sign.
  - LO=quotient and HI=remainder are written at the closing edge, then the FSM goes to IDLE.
- flush_i=1 in any state: stallreq_o=0 that cycle, next state IDLE, no HI/LO write.
- MFHI/MFLO presented while stallreq_o=1 cannot occur (pipeline held); no special handling.

Reset values while rst is high: FSM IDLE, hi_o=0, lo_o=0, stallreq_o=0, wdata_o=0, wd_o=0, wreg_o=0. Reset mid-divide discards the divide.

## Timing
- Non-divide ops: zero-latency combinational result; HI/LO visible one edge later.
- Divide, op first presented in cycle 0:
  - stallreq_o high in cycles 0..DATA_W (DATA_W+1 cycles; 33 at the default).
  - Cycle DATA_W+1 is END, stallreq_o low.
  - HI/LO are updated at the end of cycle DATA_W+1.
- Divide by zero: stallreq_o high in cycles 0–1, END in cycle 2.
- The FSM leaves END unconditionally. The pipeline advances on END, so the same op never restarts.
- Divide ops write no GPR. wreg_o still follows wreg_i; the decoder drives it to 0.

## Configuration
- EX_MULDIV_DIV_EN defined: divider FSM and datapath are built as above.
- Not defined: no divider logic. DIV/DIVU behave as NOP: no HI/LO write, stallreq_o tied 0, wdata_o=0. Multiply, MOVE and all other ops are unchanged.

## Test plan
- OR/SRA/SLT:
  - reg1=0x0000F0F0, reg2=0x0F0F0000, OR → wdata_o=0x0F0FF0F0.
  - SRA reg1=4, reg2=0x80000000 → 0xF8000000.
  - SLT reg1=0xFFFFFFFF, reg2=1 → 1.
- MULT 0xFFFFFFFF×2 → HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands → HI=1, LO=0xFFFFFFFE. Next-cycle MFHI/MFLO return the written values.
- DIV, cycle count checked:
  - DIVU 100/7 → stallreq_o high exactly 33 cycles, then LO=14, HI=2.
  - DIV 0xFFFFFFF9/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Divide by zero: DIV x/0 → stallreq_o high 2 cycles, then HI=LO=0.
- Flush: start DIVU 100/7 with HI=LO=0x12345678 preloaded via MTHI/MTLO; assert flush_i in cycle 10 → stallreq_o low that cycle, FSM IDLE, HI/LO still 0x12345678. A new DIVU then completes normally.
- Reset: assert rst asynchronously in divide cycle 5 → stallreq_o, hi_o, lo_o all 0 immediately. Repeat with EX_MULDIV_DIV_EN undefined: DIV gives no stall and no HI/LO change.
